// File: rtl/object_segmenter.sv
// Streaming Cb/Cr skin classifier: per-frame latched thresholds, 1-cycle latency, per-line counts.
// Define SEG_MAJORITY_FILTER_EN to enable the 3-tap horizontal majority filter on the output.
module object_segmenter #(
  parameter int unsigned IMG_WIDTH  = 160,
  parameter int unsigned IMG_HEIGHT = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [7:0] pix_cb,
  input  logic [7:0] pix_cr,
  input  logic [7:0] cb_min,
  input  logic [7:0] cb_max,
  input  logic [7:0] cr_min,
  input  logic [7:0] cr_max,
  output logic       object_image,
  output logic       obj_valid,
  output logic [7:0] obj_col,
  output logic [7:0] obj_row,
  output logic       line_last,
  output logic [7:0] line_count,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [7:0] LastCol = 8'(IMG_WIDTH - 1);
  localparam logic [7:0] LastRow = 8'(IMG_HEIGHT - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic       accept, restart, frame_err_d;
  logic [7:0] col_q, row_q, cur_col, cur_row;
  logic       at_last_col, at_last_row, line_start;
  logic [7:0] cb_min_q, cb_max_q, cr_min_q, cr_max_q;
  logic [7:0] cb_lo, cb_hi, cr_lo, cr_hi;
  logic       m, obj;
  logic [7:0] acc_q, acc, sum;

  logic       obj_q, valid_q, last_q, done_q, err_q;
  logic [7:0] ocol_q, orow_q, cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pix_valid && frame_start) state_d = StActive;
      StActive: if (accept && !restart && at_last_col && at_last_row) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    restart     = pix_valid && frame_start;
    accept      = pix_valid && (frame_start || (state_q == StActive));
    frame_err_d = restart && (state_q == StActive);
  end

  // A start pixel is always (0,0) and is classified with the thresholds on its own inputs.
  always_comb begin
    cur_col     = restart ? 8'd0 : col_q;
    cur_row     = restart ? 8'd0 : row_q;
    at_last_col = (cur_col == LastCol);
    at_last_row = (cur_row == LastRow);
    line_start  = (cur_col == 8'd0);
    cb_lo       = restart ? cb_min : cb_min_q;
    cb_hi       = restart ? cb_max : cb_max_q;
    cr_lo       = restart ? cr_min : cr_min_q;
    cr_hi       = restart ? cr_max : cr_max_q;
    m           = (pix_cb >= cb_lo) && (pix_cb <= cb_hi) && (pix_cr >= cr_lo) && (pix_cr <= cr_hi);
  end

`ifdef SEG_MAJORITY_FILTER_EN
  logic h1_q, h2_q, h1, h2;

  // History reads as zero at column 0, which also clears it for every new line.
  always_comb begin
    h1  = line_start ? 1'b0 : h1_q;
    h2  = line_start ? 1'b0 : h2_q;
    obj = (h1 & h2) | (h1 & m) | (h2 & m);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else if (accept) begin
      h1_q <= m;
      h2_q <= h1;
    end
  end
`else
  always_comb obj = m;
`endif

  // Saturating object-pixel count for the current line, including this pixel.
  always_comb begin
    acc = line_start ? 8'd0 : acc_q;
    sum = (acc == 8'hFF) ? acc : acc + {7'd0, obj};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q    <= 8'd0;
      row_q    <= 8'd0;
      acc_q    <= 8'd0;
      cb_min_q <= 8'd0;
      cb_max_q <= 8'd0;
      cr_min_q <= 8'd0;
      cr_max_q <= 8'd0;
    end else begin
      if (restart) begin
        cb_min_q <= cb_min;
        cb_max_q <= cb_max;
        cr_min_q <= cr_min;
        cr_max_q <= cr_max;
      end
      if (accept) begin
        acc_q <= sum;
        if (at_last_col) begin
          col_q <= 8'd0;
          row_q <= at_last_row ? 8'd0 : cur_row + 8'd1;
        end else begin
          col_q <= cur_col + 8'd1;
          row_q <= cur_row;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obj_q   <= 1'b0;
      valid_q <= 1'b0;
      ocol_q  <= 8'd0;
      orow_q  <= 8'd0;
      last_q  <= 1'b0;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      obj_q   <= accept & obj;
      valid_q <= accept;
      ocol_q  <= accept ? cur_col : 8'd0;
      orow_q  <= accept ? cur_row : 8'd0;
      last_q  <= accept & at_last_col;
      cnt_q   <= (accept && at_last_col) ? sum : 8'd0;
      done_q  <= accept & at_last_col & at_last_row & ~restart;
      err_q   <= frame_err_d;
    end
  end

  assign object_image = obj_q;
  assign obj_valid    = valid_q;
  assign obj_col      = ocol_q;
  assign obj_row      = orow_q;
  assign line_last    = last_q;
  assign line_count   = cnt_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;

endmodule

// File: doc/object_segmenter.md
# object_segmenter

Pixel-classification stage that runs directly upstream of palm identification. It takes the camera's streaming Cb/Cr chroma pixels, classifies each one as skin/object or background against per-frame thresholds, and optionally cleans the result with a 3-tap horizontal majority filter. It emits the 1-bit `object_image` stream with row/column coordinates and line/frame markers, plus a per-line object-pixel count.

## Interface
Parameters:
- `IMG_WIDTH`, default 160: pixels per line; range 3..256.
- `IMG_HEIGHT`, default 120: lines per frame; range 1..256.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset; deasserts synchronously to `clk`.
- `frame_start`, input, 1: pulse coincident with the first pixel of a frame; only meaningful when `pix_valid`=1.
- `pix_valid`, input, 1: a pixel is present this cycle. Gaps of any length are allowed.
- `pix_cb`, input, 8: Cb chroma, unsigned.
- `pix_cr`, input, 8: Cr chroma, unsigned.
- `cb_min`, `cb_max`, `cr_min`, `cr_max`, input, 8 each: inclusive skin thresholds.
- `object_image`, output, 1: classified pixel, 1 = object.
- `obj_valid`, output, 1: `object_image`, `obj_col` and `obj_row` are valid this cycle.
- `obj_col`, output, 8: column of the output pixel, 0..IMG_WIDTH-1.
- `obj_row`, output, 8: row of the output pixel, 0..IMG_HEIGHT-1.
- `line_last`, output, 1: the output pixel is the last one of its line.
- `line_count`, output, 8: number of object pixels in the line just completed. Valid with `line_last`, saturates at 255.
- `frame_done`, output, 1: one-cycle pulse with the final pixel of the frame.
- `frame_err`, output, 1: one-cycle pulse when a frame restarts before the previous one completed.

## Operation
- FSM states: IDLE and ACTIVE. Reset enters IDLE.
- IDLE:
  - `pix_valid`=1 with `frame_start`=0: pixel ignored, no output.
  - `pix_valid`=1 with `frame_start`=1: move to ACTIVE and process the pixel as (row 0, col 0).
- Threshold latching:
  - Thresholds are latched on the accepted `frame_start` pixel and used for that entire frame, including the start pixel itself.
  - Changes to the threshold inputs mid-frame have no effect until the next frame.
- Classification: `m` = (`cb_min` <= `pix_cb` <= `cb_max`) AND (`cr_min` <= `pix_cr` <= `cr_max`).
  - If a min exceeds its max, `m` = 0 for every pixel.
- Counters:
  - Column advances only on accepted pixels.
  - At col IMG_WIDTH-1 the column wraps to 0 and the row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) the output carries `frame_done`=1 and the FSM returns to IDLE.
- Line count:
  - Accumulates the final `object_image` values across the line.
  - Presented alongside `line_last`, then cleared for the next line.
- `frame_start` while ACTIVE:
  - Pulse `frame_err`.
  - Discard the partial frame: no `frame_done` is issued for it.
  - Re-latch the thresholds and restart counters at (0,0) with the current pixel. The line count and filter history are cleared.
- Reset mid-frame: all state returns to reset values immediately (asynchronously).

## Timing
- Latency: exactly 1 cycle from an accepted input pixel to its `obj_valid`, in both configurations.
- `obj_valid` is high for exactly one cycle per accepted pixel, with no output during input gaps.
- Reset values:
  - `object_image`, `obj_valid`, `obj_col`, `obj_row`, `line_last`, `frame_done`, `frame_err` = 0.
  - `line_count` = 0.
  - Latched thresholds = 0; filter history = 0; FSM = IDLE.
- `line_last`, `line_count`, `frame_done` and `frame_err` are asserted only in a cycle where `obj_valid` = 1.

## Configuration
- `SEG_MAJORITY_FILTER_EN` defined:
  - `object_image` for column c = majority(m[c-2], m[c-1], m[c]).
  - History bits for columns before 0 are treated as 0, and history is cleared at every line start.
  - Latency stays 1 cycle.
- Not defined: `object_image` = m[c]; no history registers.

## Test plan
- Reset, then a 160x120 frame with every pixel Cb=Cr=128 and thresholds 100..150 → 19200 outputs, all `object_image`=1. Each `line_last` has `line_count`=160; `frame_done` is asserted once, on (119,159).
- `pix_valid`=1 for 10 cycles without `frame_start`, then a valid frame → no output during the 10 cycles; the first output is (0,0), one cycle after `frame_start`.
- Change the thresholds to 200..210 mid-frame → classification stays unchanged until the next `frame_start`; the next frame is all 0 with `line_count`=0.
- Filter enabled, line pattern m = 0,1,0,1,1,0,... → outputs are 0,0,0,1,1,1, and the first two columns of each line are 0 regardless of the previous line. Filter disabled → the output equals m.
- `frame_start` at (5,20) → `frame_err` pulses once, the output restarts at (0,0), and the aborted frame produces no `frame_done`.
- Assert `rst` at (3,40) with random `pix_valid` gaps → all outputs are 0 immediately, and pixels are ignored until the next `frame_start`.
